// File: rtl/mdl_pg_phaseacc.sv
// Phase generator accumulator: applies MUL to the per-slot increment and keeps a
// 20-bit phase per operator slot in a 32-entry circular shift register.
module mdl_pg_phaseacc (
  input  logic        i_EMUCLK,
  input  logic        i_MRST_n,
  input  logic        i_phi1_PCEN_n,
  input  logic        i_phi1_NCEN_n,
  input  logic        i_CYCLE_00,
  input  logic [16:0] i_PHASE_INCR,
  input  logic [3:0]  i_MUL,
  input  logic        i_PHASE_RST,
  input  logic        i_TEST_PGRST,
  output logic [9:0]  o_OP_PHASEDATA,
  output logic [4:0]  o_SLOT_IDX
);
  localparam int SLOTS   = 32;
  localparam int PHASE_W = 20;

  // MUL==0 means x0.5; otherwise the 21-bit product loses its top bit.
  function automatic logic [PHASE_W-1:0] mul_trunc(input logic [16:0] incr,
                                                   input logic [3:0]  mul);
    logic [PHASE_W-1:0] prod;
    if (mul == 4'd0)
      prod = {4'b0, incr[16:1]};
    else
      prod = 20'(incr) * 20'(mul);
    return prod;
  endfunction

  function automatic logic [PHASE_W-1:0] phase_next(input logic               rst,
                                                    input logic [PHASE_W-1:0] old_phase,
                                                    input logic [PHASE_W-1:0] prod);
    return rst ? '0 : old_phase + prod;
  endfunction

  logic w_tick;
  logic w_unused_pcen;
  assign w_tick        = ~i_phi1_NCEN_n;
  assign w_unused_pcen = i_phi1_PCEN_n;

  logic [16:0]        r_incr_p1;
  logic [3:0]         r_mul_p1;
  logic               r_rst_p1;
  logic [4:0]         r_slot_p1;
  logic [PHASE_W-1:0] r_prod_p2;
  logic               r_rst_p2;
  logic [4:0]         r_slot_p2;
  logic [PHASE_W-1:0] r_ring [SLOTS];
  logic [9:0]         r_phase_p3;
  logic [4:0]         r_slot_p3;
  logic [PHASE_W-1:0] w_new_phase;

  // Tap 31 holds the value written for this same slot 32 ticks ago.
  assign w_new_phase = phase_next(r_rst_p2, r_ring[SLOTS-1], r_prod_p2);

  always_ff @(posedge i_EMUCLK) begin
    if (!i_MRST_n) begin
      r_incr_p1  <= '0;
      r_mul_p1   <= '0;
      r_rst_p1   <= 1'b0;
      r_slot_p1  <= '0;
      r_prod_p2  <= '0;
      r_rst_p2   <= 1'b0;
      r_slot_p2  <= '0;
      r_phase_p3 <= '0;
      r_slot_p3  <= '0;
      for (int i = 0; i < SLOTS; i++) r_ring[i] <= '0;
    end else if (w_tick) begin
      // S1: input capture; the S1 slot register doubles as the slot counter
      r_incr_p1 <= i_PHASE_INCR;
      r_mul_p1  <= i_MUL;
      r_rst_p1  <= i_PHASE_RST | i_TEST_PGRST;
      r_slot_p1 <= i_CYCLE_00 ? 5'd0 : r_slot_p1 + 5'd1;
      // S2: frequency multiply
      r_prod_p2 <= mul_trunc(r_incr_p1, r_mul_p1);
      r_rst_p2  <= r_rst_p1;
      r_slot_p2 <= r_slot_p1;
      // S3: accumulate, write ring head, register outputs
      for (int i = SLOTS-1; i > 0; i--) r_ring[i] <= r_ring[i-1];
      r_ring[0]  <= w_new_phase;
      r_phase_p3 <= w_new_phase[PHASE_W-1:PHASE_W-10];
      r_slot_p3  <= r_slot_p2;
    end
  end

  assign o_OP_PHASEDATA = r_phase_p3;
  assign o_SLOT_IDX     = r_slot_p3;
endmodule

// File: tb/tb_mdl_pg_phaseacc.sv
// Directed bench for mdl_pg_phaseacc with a tick-position phase model and an
// expected-output queue popped three ticks after each stimulus tick.
module tb_mdl_pg_phaseacc;
  logic        clk = 1'b0;
  logic        mrst_n = 1'b0;
  logic        pcen_n = 1'b1;
  logic        ncen_n = 1'b1;
  logic        cyc00 = 1'b0;
  logic [16:0] incr = '0;
  logic [3:0]  mul = '0;
  logic        prst = 1'b0;
  logic        tpg = 1'b0;
  logic [9:0]  phasedata;
  logic [4:0]  slot_idx;

  mdl_pg_phaseacc dut (
    .i_EMUCLK       (clk),
    .i_MRST_n       (mrst_n),
    .i_phi1_PCEN_n  (pcen_n),
    .i_phi1_NCEN_n  (ncen_n),
    .i_CYCLE_00     (cyc00),
    .i_PHASE_INCR   (incr),
    .i_MUL          (mul),
    .i_PHASE_RST    (prst),
    .i_TEST_PGRST   (tpg),
    .o_OP_PHASEDATA (phasedata),
    .o_SLOT_IDX     (slot_idx)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [19:0] mph [32];
  logic [4:0]  mcnt;
  int          tcount;
  logic [14:0] expq [$];
  logic [9:0]  obs [32];
  logic [16:0] tab_incr [32];
  logic [3:0]  tab_mul [32];
  int          prst_slot = -1;
  logic        tpg_round = 1'b0;

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] model_prod(input logic [16:0] i, input logic [3:0] m);
    logic [20:0] full;
    logic [19:0] p;
    full = {4'b0, i} * {17'b0, m};
    p = (m == 4'd0) ? {4'b0, i[16:1]} : full[19:0];
    return p;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mph[i] = '0;
      obs[i] = '0;
    end
    mcnt   = '0;
    tcount = 0;
    expq.delete();
  endtask

  task automatic do_tick(input logic c, input logic [16:0] inc, input logic [3:0] m,
                         input logic pr, input logic tp);
    int          pos;
    logic [14:0] e;
    @(negedge clk);
    cyc00 = c; incr = inc; mul = m; prst = pr; tpg = tp; ncen_n = 1'b0;
    mcnt = c ? 5'd0 : mcnt + 5'd1;
    pos  = tcount % 32;
    mph[pos] = (pr | tp) ? 20'd0 : mph[pos] + model_prod(inc, m);
    expq.push_back({mcnt, mph[pos][19:10]});
    tcount++;
    @(posedge clk);
    #1;
    if (expq.size() == 3) begin
      e = expq.pop_front();
      chk("slot_idx", {15'b0, slot_idx}, {15'b0, e[14:10]});
      chk("phasedata", {10'b0, phasedata}, {10'b0, e[9:0]});
      obs[e[14:10]] = phasedata;
    end
  endtask

  task automatic run_slots(input int from, input int to);
    for (int s = from; s <= to; s++)
      do_tick(s == 0, tab_incr[s], tab_mul[s], s == prst_slot, tpg_round);
  endtask

  task automatic do_reset();
    @(negedge clk);
    mrst_n = 1'b0; ncen_n = 1'b0;
    incr = 17'h1ABCD; mul = 4'd5; cyc00 = 1'b1;
    @(negedge clk);
    ncen_n = 1'b1;
    @(negedge clk);
    mrst_n = 1'b1; cyc00 = 1'b0; incr = '0; mul = '0;
    chk("rst_data", {10'b0, phasedata}, 20'd0);
    chk("rst_slot", {15'b0, slot_idx}, 20'd0);
    model_clear();
  endtask

  task automatic set_tab(input logic [16:0] inc, input logic [3:0] m);
    for (int s = 0; s < 32; s++) begin
      tab_incr[s] = inc;
      tab_mul[s]  = m;
    end
  endtask

  logic [9:0] save_d;
  logic [4:0] save_s;
  logic [9:0] nv;

  initial begin
    // reset state, then idle accumulation with zero increment
    do_reset();
    set_tab(17'h0, 4'd1);
    run_slots(0, 31);
    run_slots(0, 31);
    chk("idle_s0", {10'b0, obs[0]}, 20'd0);

    // linear accumulation on slot 0 with wrap at round 1024
    do_reset();
    set_tab(17'h0, 4'd1);
    tab_incr[0] = 17'h00400;
    for (int n = 1; n <= 1024; n++) begin
      run_slots(0, 31);
      nv = 10'(n);
      if (n == 1 || n == 2 || n == 3 || n == 513 || n == 1023 || n == 1024) begin
        chk("lin_s0", {10'b0, obs[0]}, {10'b0, nv});
        chk("lin_s9", {10'b0, obs[9]}, 20'd0);
      end
    end

    // half multiplier on slot 3
    do_reset();
    set_tab(17'h0, 4'd1);
    tab_incr[3] = 17'h00801; tab_mul[3] = 4'd0;
    for (int n = 1; n <= 4; n++) begin
      run_slots(0, 31);
      nv = 10'(n);
      chk("half_s3", {10'b0, obs[3]}, {10'b0, nv});
    end

    // maximum product truncation on slot 7
    do_reset();
    set_tab(17'h0, 4'd1);
    tab_incr[7] = 17'h1FFFF; tab_mul[7] = 4'd15;
    run_slots(0, 31);
    chk("max_r1", {10'b0, obs[7]}, 20'h0037F);
    run_slots(0, 31);
    chk("max_r2", {10'b0, obs[7]}, 20'h002FF);

    // key-on reset on slot 5, then test reset over a whole round
    do_reset();
    set_tab(17'h00400, 4'd2);
    for (int n = 1; n <= 9; n++) run_slots(0, 31);
    prst_slot = 5;
    run_slots(0, 31);
    prst_slot = -1;
    chk("kon_r10_s5", {10'b0, obs[5]}, 20'd0);
    chk("kon_r10_s0", {10'b0, obs[0]}, 20'd20);
    chk("kon_r10_s20", {10'b0, obs[20]}, 20'd20);
    run_slots(0, 31);
    chk("kon_r11_s5", {10'b0, obs[5]}, 20'd2);
    chk("kon_r11_s0", {10'b0, obs[0]}, 20'd22);
    tpg_round = 1'b1;
    run_slots(0, 31);
    tpg_round = 1'b0;
    chk("tpg_s0", {10'b0, obs[0]}, 20'd0);
    chk("tpg_s29", {10'b0, obs[29]}, 20'd0);
    run_slots(0, 31);
    chk("tpg_next_s5", {10'b0, obs[5]}, 20'd2);

    // stall mid-round for 100 clocks with inputs wiggling
    run_slots(0, 14);
    save_d = phasedata;
    save_s = slot_idx;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      ncen_n = 1'b1;
      incr = 17'($urandom); mul = 4'($urandom); cyc00 = 1'($urandom);
      prst = 1'($urandom); tpg = 1'($urandom);
    end
    @(negedge clk);
    chk("stall_data", {10'b0, phasedata}, {10'b0, save_d});
    chk("stall_slot", {15'b0, slot_idx}, {15'b0, save_s});
    run_slots(15, 31);
    run_slots(0, 31);
    chk("stall_resume_s0", {10'b0, obs[0]}, 20'd6);
    chk("stall_resume_s20", {10'b0, obs[20]}, 20'd6);

    // spurious CYCLE_00 resyncs the slot counter two ticks later at the output
    run_slots(0, 9);
    do_tick(1'b1, tab_incr[10], tab_mul[10], 1'b0, 1'b0);
    do_tick(1'b0, tab_incr[11], tab_mul[11], 1'b0, 1'b0);
    do_tick(1'b0, tab_incr[12], tab_mul[12], 1'b0, 1'b0);
    chk("resync_slot", {15'b0, slot_idx}, 20'd0);
    run_slots(13, 31);
    run_slots(0, 31);

    // reset mid-operation clears the ring
    do_reset();
    set_tab(17'h0, 4'd3);
    run_slots(0, 31);
    run_slots(0, 31);
    chk("midrst_s5", {10'b0, obs[5]}, 20'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
